// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and the per-layer configuration table for the CNN layer sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_pkg;

    // Configuration field width baked into the layer table.
    localparam int CFG_W      = 8;
    // Table depth; the sequencer may run fewer layers than this.
    localparam int MAX_LAYERS = 8;

    typedef enum logic [1:0] {
        CONV = 2'd0,
        RELU = 2'd1,
        POOL = 2'd2,
        FC   = 2'd3
    } layer_type_e;

    typedef struct packed {
        layer_type_e        ltype;
        logic [CFG_W-1:0]   in_w;
        logic [CFG_W-1:0]   in_h;
        logic [CFG_W-1:0]   k_x;
        logic [CFG_W-1:0]   k_y;
        logic [CFG_W-1:0]   out_batch;
        logic [4:0]         wt_shift;
    } layer_cfg_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GO   = 3'd2,
        S_RUN  = 3'd3,
        S_SWAP = 3'd4,
        S_FIN  = 3'd5
    } sched_state_e;

    // LeNet-style network; pooling/ReLU rows carry a zero shift since they do not accumulate.
    localparam layer_cfg_t LAYER_TABLE [MAX_LAYERS] = '{
        '{CONV, 8'd32, 8'd32, 8'd5, 8'd5, 8'd6,   5'd8 },
        '{POOL, 8'd28, 8'd28, 8'd2, 8'd2, 8'd6,   5'd0 },
        '{CONV, 8'd14, 8'd14, 8'd5, 8'd5, 8'd16,  5'd9 },
        '{POOL, 8'd10, 8'd10, 8'd2, 8'd2, 8'd16,  5'd0 },
        '{FC,   8'd5,  8'd5,  8'd5, 8'd5, 8'd120, 5'd10},
        '{RELU, 8'd1,  8'd1,  8'd1, 8'd1, 8'd120, 5'd0 },
        '{FC,   8'd1,  8'd1,  8'd1, 8'd1, 8'd84,  5'd7 },
        '{FC,   8'd1,  8'd1,  8'd1, 8'd1, 8'd10,  5'd7 }
    };

endpackage

// File: rtl/cnn_layer_cfg_rom.sv
// cnn_layer_cfg_rom: combinational layer index -> layer_cfg_t lookup.
// Latency: 0 cycles (pure combinational; the caller registers the result).
// Backpressure: none. Ports: i_idx layer index in, o_cfg config out (out-of-range -> layer 0).
module cnn_layer_cfg_rom
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS = 5,
    parameter int W_LAYER    = 3
) (
    input  logic [W_LAYER-1:0] i_idx,
    output layer_cfg_t         o_cfg
);

    always_comb begin
        o_cfg = LAYER_TABLE[0];
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (int'(i_idx) == i) begin
                o_cfg = LAYER_TABLE[i];
            end
        end
    end

endmodule

// File: rtl/cnn_layer_sched.sv
// cnn_layer_sched: sequences NUM_LAYERS layer passes (LOAD/GO/RUN/SWAP) and ping-pongs activation banks.
// Latency: start -> first layer_go 2 cycles; 3 cycles of overhead per layer; done 2 cycles after last layer_done.
// Backpressure: none; start is ignored while busy, abort (level) returns to IDLE from any state.
// Ports: clk/rstn; start/abort/layer_done in; busy/done/layer_go, layer_idx, cfg (layer_type,in_w,in_h,k_x,k_y,
// out_batch,wt_shift), rd_bank/wr_bank out. Macro CNN_SCHED_PERF_EN adds cyc_cnt/layer_cyc counters.
module cnn_layer_sched
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS = 5,
    parameter int W_LAYER    = 3,
    parameter int W_DIM      = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic               layer_done,
    output logic               busy,
    output logic               done,
    output logic               layer_go,
    output logic [W_LAYER-1:0] layer_idx,
    output logic [1:0]         layer_type,
    output logic [W_DIM-1:0]   in_w,
    output logic [W_DIM-1:0]   in_h,
    output logic [W_DIM-1:0]   k_x,
    output logic [W_DIM-1:0]   k_y,
    output logic [W_DIM-1:0]   out_batch,
    output logic [4:0]         wt_shift,
    output logic               rd_bank,
    output logic               wr_bank
`ifdef CNN_SCHED_PERF_EN
    ,
    output logic [31:0]        cyc_cnt,
    output logic [31:0]        layer_cyc
`endif
);

    localparam logic [W_LAYER-1:0] LAST_IDX = W_LAYER'(NUM_LAYERS - 1);

    sched_state_e       r_state;
    sched_state_e       w_state_nxt;
    logic [W_LAYER-1:0] r_idx;
    logic [W_LAYER-1:0] w_idx_nxt;
    logic               r_rd_bank;
    layer_cfg_t         r_cfg;
    layer_cfg_t         w_rom_cfg;

    // The ROM looks up the index the FSM is about to enter LOAD with, so the
    // registered config is already stable during LOAD, one cycle ahead of go.
    cnn_layer_cfg_rom #(
        .NUM_LAYERS (NUM_LAYERS),
        .W_LAYER    (W_LAYER)
    ) u_cfg_rom (
        .i_idx (w_idx_nxt),
        .o_cfg (w_rom_cfg)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_idx_nxt   = '0;
                end
            end
            S_LOAD: w_state_nxt = S_GO;
            S_GO:   w_state_nxt = S_RUN;
            S_RUN: begin
                if (layer_done) begin
                    w_state_nxt = S_SWAP;
                end
            end
            S_SWAP: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_LOAD;
                    w_idx_nxt   = r_idx + W_LAYER'(1);
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // abort overrides every transition, including a same-cycle start.
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_rd_bank <= 1'b0;
            r_cfg     <= LAYER_TABLE[0];
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (abort) begin
                r_rd_bank <= 1'b0;
            end else if ((r_state == S_IDLE) && start) begin
                r_rd_bank <= 1'b0;
            end else if (r_state == S_SWAP) begin
                r_rd_bank <= ~r_rd_bank;
            end
            if (w_state_nxt == S_LOAD) begin
                r_cfg <= w_rom_cfg;
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign layer_go   = (r_state == S_GO)  && !abort;
    assign done       = (r_state == S_FIN) && !abort;
    assign layer_idx  = r_idx;
    assign rd_bank    = r_rd_bank;
    assign wr_bank    = ~r_rd_bank;
    assign layer_type = r_cfg.ltype;
    assign in_w       = W_DIM'(r_cfg.in_w);
    assign in_h       = W_DIM'(r_cfg.in_h);
    assign k_x        = W_DIM'(r_cfg.k_x);
    assign k_y        = W_DIM'(r_cfg.k_y);
    assign out_batch  = W_DIM'(r_cfg.out_batch);
    assign wt_shift   = r_cfg.wt_shift;

`ifdef CNN_SCHED_PERF_EN
    // cyc_cnt counts completed busy cycles, so the final total is visible the
    // cycle after done. r_run_cnt counts RUN cycles of the current layer.
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_run_cnt;
    logic [31:0] r_layer_cyc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cyc_cnt   <= '0;
            r_run_cnt   <= '0;
            r_layer_cyc <= '0;
        end else if (abort) begin
            r_cyc_cnt   <= '0;
            r_run_cnt   <= '0;
            r_layer_cyc <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_cyc_cnt <= '0;
            end else if (busy && (r_cyc_cnt != 32'hFFFF_FFFF)) begin
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
            end
            if (r_state == S_GO) begin
                r_run_cnt <= '0;
            end else if ((r_state == S_RUN) && (r_run_cnt != 32'hFFFF_FFFF)) begin
                r_run_cnt <= r_run_cnt + 32'd1;
            end
            if (r_state == S_SWAP) begin
                r_layer_cyc <= r_run_cnt;
            end
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign layer_cyc = r_layer_cyc;
`endif

endmodule
